// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: serial adder FSM encoding and default width.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } serial_state_t;

  localparam int SERIAL_WIDTH = 8;

endpackage

// File: rtl/full_adder_gatelevel_module.sv
// One-bit full adder built from gate primitives; the per-bit cell of the serial adder.
module full_adder_gatelevel_module (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (sum, ab_x, cin);
  and g_a0 (ab_a, a, b);
  and g_a1 (cx_a, ab_x, cin);
  or  g_o0 (cout, ab_a, cx_a);

endmodule

// File: rtl/serial_adder_controller.sv
// Bit-serial WIDTH-bit adder: one full adder reused LSB-first, carry held in a flop,
// operands in and result out over valid/ready handshakes.
module serial_adder_controller
  import arith_pkg::*;
#(
  parameter  int WIDTH = SERIAL_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  serial_state_t    state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             c_msb;
  logic             out_valid_r;
  logic             busy_r;
  logic             fa_sum;
  logic             fa_cout;

  full_adder_gatelevel_module u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      cnt         <= '0;
      carry       <= 1'b0;
      c_msb       <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // flush outranks in_valid so an abort can never race a new accept
          if (in_valid && !flush) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
            busy_r <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush) begin
            busy_r <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
            carry  <= fa_cout;
            cnt    <= cnt + 1'b1;
            // carry into the MSB is kept so overflow can be formed against cout
            if (cnt == LAST_BIT) begin
              c_msb       <= carry;
              out_valid_r <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (flush || out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_sh;
  assign cout      = carry;
  assign overflow  = c_msb ^ carry;

endmodule

// File: tb/tb_serial_adder_controller.sv
// Directed bench for serial_adder_controller at WIDTH=8 with hand-computed results.
module tb_serial_adder_controller;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  serial_adder_controller #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int i;
    for (i = 0; i < 20 && in_ready !== 1'b1; i++) step();
    chk("rdy_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // One full transaction; hold = cycles out_ready stays low once DONE is reached.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic [W-1:0] es, input logic ec,
                        input logic eo, input int hold);
    wait_ready();
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    a = ~ta; b = ~tb; cin = ~tc;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    repeat (W - 1) step();
    chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    chk({tag, "_rdy_lo"}, {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_vld"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_sum"}, {24'd0, sum}, {24'd0, es});
      chk({tag, "_hold_ovf"}, {31'd0, overflow}, {31'd0, eo});
      chk({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk({tag, "_end_vld"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_end_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [W-1:0] qa [3];
  logic [W-1:0] qb [3];
  logic         qc [3];
  int           acc_cyc [3];

  initial begin
    #2;
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {24'd0, sum, cout, overflow} >> 2, 32'd0);
    #10 reset_n = 1'b1;
    step();

    run_op("p5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);
    run_op("pff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_op("pff00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    run_op("p7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 5);

    // Asynchronous reset during the third RUN cycle.
    wait_ready();
    a = 8'h5A; b = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_vld", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rdy", {31'd0, in_ready}, 32'd1);
    chk("arst_sum", {24'd0, sum}, 32'd0);
    step();
    reset_n = 1'b1;
    run_op("p1020", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);

    // flush in the fourth RUN cycle
    wait_ready();
    a = 8'h11; b = 8'h22; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_rdy", {31'd0, in_ready}, 32'd1);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    begin
      int pulses = 0;
      for (int i = 0; i < 12; i++) begin
        if (out_valid) pulses++;
        step();
      end
      chk("flush_nopulse", pulses, 32'd0);
    end

    // flush together with in_valid in IDLE blocks the accept
    flush = 1'b1; in_valid = 1'b1; a = 8'h01; b = 8'h01;
    step();
    chk("flush_idle_rdy", {31'd0, in_ready}, 32'd1);
    chk("flush_idle_busy", {31'd0, busy}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    step();

    // Back-to-back with in_valid held high
    qa[0] = 8'h12; qb[0] = 8'h34; qc[0] = 1'b1;
    qa[1] = 8'h80; qb[1] = 8'h80; qc[1] = 1'b0;
    qa[2] = 8'($urandom); qb[2] = 8'($urandom); qc[2] = 1'($urandom);
    begin
      int acc_i = 0;
      int res_i = 0;
      logic [W:0] full;
      logic eo;
      out_ready = 1'b1;
      a = qa[0]; b = qb[0]; cin = qc[0]; in_valid = 1'b1;
      for (int cyc = 0; cyc < 60 && res_i < 3; cyc++) begin
        logic took;
        took = in_valid && in_ready;
        step();
        if (took) begin
          acc_cyc[acc_i] = cyc;
          acc_i++;
          if (acc_i < 3) begin
            a = qa[acc_i]; b = qb[acc_i]; cin = qc[acc_i];
          end else in_valid = 1'b0;
        end
        if (out_valid) begin
          full = {1'b0, qa[res_i]} + {1'b0, qb[res_i]} + {8'd0, qc[res_i]};
          eo = (qa[res_i][W-1] == qb[res_i][W-1]) && (full[W-1] != qa[res_i][W-1]);
          chk($sformatf("b2b%0d_sum", res_i), {24'd0, sum}, {24'd0, full[W-1:0]});
          chk($sformatf("b2b%0d_cout", res_i), {31'd0, cout}, {31'd0, full[W]});
          chk($sformatf("b2b%0d_ovf", res_i), {31'd0, overflow}, {31'd0, eo});
          res_i++;
        end
      end
      in_valid = 1'b0;
      chk("b2b_results", res_i, 32'd3);
      chk("b2b_accepts", acc_i, 32'd3);
      if (acc_i == 3) begin
        chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 32'd10);
        chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], 32'd10);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder_controller.md
Name: serial_adder_controller

Overview:
Bit-serial WIDTH-bit adder built around a single 1-bit gate-level full adder. The block accepts one operand pair over a valid/ready handshake and sequences the full adder once per clock from LSB to MSB, keeping the carry in a register. It then returns sum, carry-out and signed overflow over a second valid/ready handshake. It is the area-minimal alternative to the ripple adders in the Arithmetic datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit-position counter width; derived, not overridden.

Ports:
clk  input  1  single clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand pair a/b/cin is valid.
in_ready  output  1  block can accept operands (IDLE only).
a  input  WIDTH  operand A, sampled on accept.
b  input  WIDTH  operand B, sampled on accept.
cin  input  1  carry-in, sampled on accept.
flush  input  1  synchronous abort; returns to IDLE and discards the result.
out_valid  output  1  result valid (DONE only).
out_ready  input  1  consumer takes the result.
sum  output  WIDTH  registered sum.
cout  output  1  carry out of the MSB.
overflow  output  1  signed overflow, defined as carry into MSB XOR carry out of MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock domain. reset_n is asynchronous, active-low; all flops clear immediately on its assertion.
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, busy=0. Shift registers, sum, cout, overflow, carry and counter are all 0.
- State machine: IDLE, RUN, DONE, with a 2-bit encoding. The unused code 2'b11 returns to IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum_sh<=0, then go to RUN.
  - in_valid without an accept is ignored.
- RUN, one bit per cycle:
  - Full adder inputs are a_sh[0], b_sh[0] and carry.
  - a_sh and b_sh shift right by one.
  - sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]}, so the LSB is produced first.
  - carry <= fa_cout; cnt <= cnt+1.
  - When cnt==WIDTH-1: store the carry-in of this MSB cycle in c_msb, and on the same edge go to DONE.
  - a, b and cin are ignored while in RUN.
- DONE:
  - out_valid=1; sum=sum_sh; cout=carry; overflow=c_msb^carry.
  - Outputs stay stable while out_ready=0.
  - On out_ready=1, go to IDLE on that edge.
- Latency: the accept edge is cycle 0. out_valid is high starting from the cycle after edge WIDTH, i.e. WIDTH+1 cycles after accept.
- Throughput: at most one operation per WIDTH+2 cycles, because in_ready is low in DONE (no accept/deliver overlap).
- flush:
  - In RUN or DONE, flush forces IDLE on the next edge and clears out_valid; the result is lost.
  - In IDLE, flush blocks the accept for that cycle (flush has priority over in_valid).
- Reset mid-operation: state and data registers clear asynchronously. The first cycle after reset_n rises is IDLE with in_ready=1; there is no partial result.
- Arithmetic: result = (a+b+cin) mod 2^WIDTH, with cout equal to bit WIDTH of the full sum. There is no sign extension and no saturation.

Decomposition:
- Shared package/include arith_pkg: state encodings ST_IDLE/ST_RUN/ST_DONE and the default SERIAL_WIDTH=8.
- One sub-module: instantiate the team's existing full_adder_gatelevel_module once for the per-bit add.
- The FSM, counter and shift registers stay in serial_adder_controller. No other hierarchy.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 → out_valid at accept+9 cycles; sum=0x96, cout=0, overflow=1.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0. Then a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1, overflow=0.
- a=0x7F, b=0x01, cin=0 with out_ready held 0 for 5 cycles in DONE → sum=0x80, cout=0, overflow=1. Outputs stay stable and in_ready=0 throughout; the op completes on the edge after out_ready=1.
- Drop reset_n low during the 3rd RUN cycle → out_valid=0, busy=0, in_ready=1 immediately. After release, a new op (0x10+0x20) yields 0x30.
- Assert flush in the 4th RUN cycle → IDLE next cycle with no out_valid pulse. Also assert flush together with in_valid in IDLE → no accept.
- Back-to-back: in_valid held high with 3 operand pairs and out_ready=1 → accepts are exactly 10 cycles apart and each result is correct, including a random pair checked against a+b+cin.
